frame_buffer_ctrl: RTL and testbench
====================================

FRAME_BUFFER_CTRL -- requirements
Module: frame_buffer_ctrl

Interface
REQ-001 Parameters SHALL be:
- DISPLAY_WIDTH, default `DISPLAY_WIDTH, pixels per row.
- DISPLAY_HEIGHT, default `DISPLAY_HEIGHT, rows per frame.
- H_BITS, default `H_BITS, column index width.
- V_BITS, default `V_BITS, row index width.
- COLOR_BITS, default `COLOR_BITS, pixel color width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_in  in  1  sole clock.
- rst_in  in  1  asynchronous active-high reset.
- hcount_in  in  H_BITS  rendered pixel column.
- vcount_in  in  V_BITS  rendered pixel row.
- color_in  in  COLOR_BITS  rendered pixel color.
- valid_in  in  1  pixel write strobe.
- new_frame_in  in  1  level, high for one or more cycles when the renderer starts a frame.
- disp_hcount_in  in  H_BITS  display read column.
- disp_vcount_in  in  V_BITS  display read row.
- vblank_start_in  in  1  one-cycle pulse at the start of display vertical blank.
- disp_color_out  out  COLOR_BITS  pixel color for the display.
- frame_count_out  out  8  count of completed rendered frames.
- swap_pending_out  out  1  a completed frame is waiting for vblank.

Function
REQ-003 Storage SHALL be triple-buffered: three banks (indices 0..2) of DISPLAY_WIDTH*DISPLAY_HEIGHT entries, each COLOR_BITS wide.
REQ-004 State SHALL be: write_bank (2b), display_bank (2b), ready_bank (2b), ready_valid (1b), started (1b), and a registered copy of new_frame_in for rising-edge detection.
REQ-005 Frame-start edge SHALL be new_frame_in high while its registered copy is low; holding the input high for many cycles SHALL count as one edge.
REQ-006 On the first edge after reset (started=0), only started SHALL be set; no bank change and no count.
REQ-007 On later edges without vblank_start_in: ready_bank<=write_bank, ready_valid<=1, write_bank<=3-write_bank-display_bank, frame_count_out<=frame_count_out+1 (wraps at 8 bits).
REQ-008 On vblank_start_in without an edge, if ready_valid: display_bank<=ready_bank and ready_valid<=0. If ready_valid=0, nothing changes.
REQ-009 On an edge and vblank_start_in in the same cycle (started=1): display_bank<=write_bank, write_bank<=old display_bank, ready_valid<=0, frame_count_out increments.
REQ-010 Invariant: write_bank SHALL never equal display_bank, and, when ready_valid=1, never equal ready_bank.
REQ-011 Write path SHALL be 2 stages:
- stage 1 registers addr = write_bank*W*H + vcount_in*W + hcount_in, plus color and valid;
- stage 2 drives the BRAM write port.
REQ-012 Writes with hcount_in>=DISPLAY_WIDTH, vcount_in>=DISPLAY_HEIGHT, or started=0 SHALL be dropped.
REQ-013 The bank used for a write SHALL be sampled in stage 1, so a pixel accepted in the same cycle as an edge goes to the old write bank.
REQ-014 Read path: disp_color_out SHALL reflect the pixel at (disp_hcount_in, disp_vcount_in) of display_bank exactly 3 cycles after presentation (1 address register plus 2 BRAM cycles).
REQ-015 Out-of-range read coordinates SHALL yield disp_color_out=0 at the same latency.
REQ-016 swap_pending_out SHALL equal ready_valid.
REQ-017 The multiplier SHALL be sized to the full address width, clog2(3*W*H); products SHALL NOT truncate.

Reset
REQ-018 rst_in SHALL asynchronously force:
- write_bank=1, display_bank=0, ready_bank=0;
- ready_valid=0, started=0, edge register=0;
- frame_count_out=0, disp_color_out=0, swap_pending_out=0;
- all pipeline valid bits=0.
REQ-019 Reset mid-frame SHALL discard in-flight writes; BRAM contents are not cleared.

Structure
REQ-020 The constants DISPLAY_WIDTH/HEIGHT, H_BITS, V_BITS, COLOR_BITS and the bank index width SHALL come from the shared types header.
REQ-021 Storage SHALL be one sub-module, frame_bram: simple dual-port BRAM, one write port and one read port, 2-cycle read latency, same clock.

Verification (W=8, H=4, COLOR_BITS=4)
REQ-022 Reset, then display reads of (0,0) -> disp_color_out=0; frame_count_out=0; swap_pending_out=0.
REQ-023 Edge, then write (3,2)=0xA, then second edge -> frame_count_out=1, swap_pending_out=1; after a vblank_start_in pulse, reading (3,2) gives 0xA three cycles later and swap_pending_out=0.
REQ-024 new_frame_in held high 5 cycles -> a single edge; frame_count_out increments once only.
REQ-025 Edge coincident with vblank_start_in while rendering bank 1 over displayed bank 0 -> display_bank=1, write_bank=0, ready_valid=0.
REQ-026 Write at hcount=8 or vcount=4 -> no BRAM write enable; display bank contents unchanged.
REQ-027 Three completed frames with no vblank between them -> write_bank never equals display_bank (checked every cycle by assertion); after vblank, the most recent frame is displayed.

Source files
------------

// File: rtl/frame_buffer_ctrl_pkg.sv
// Shared constants and types for the triple-buffered frame buffer controller.
// Display geometry defaults, bank indexing and bank-rotation helpers live here.
package frame_buffer_ctrl_pkg;

    localparam int DISPLAY_WIDTH     = 8;
    localparam int DISPLAY_HEIGHT    = 4;
    localparam int H_BITS            = 4;
    localparam int V_BITS            = 3;
    localparam int COLOR_BITS        = 4;
    localparam int BANK_BITS         = 2;
    localparam int NUM_BANKS         = 3;
    localparam int BRAM_READ_LATENCY = 2;

    typedef logic [BANK_BITS-1:0] bank_t;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_START,
        EV_COMPLETE,
        EV_PRESENT,
        EV_COMPLETE_SWAP
    } bank_event_e;

    // Banks are 0..2, so the one that is neither a nor b is 3-a-b.
    function automatic bank_t third_bank(input bank_t a, input bank_t b);
        return bank_t'(2'd3 - a - b);
    endfunction

endpackage

// File: rtl/frame_buffer_ctrl_bram.sv
// Simple dual-port block RAM: one write port, one read port, two-cycle
// registered read latency, single clock.
module frame_bram #(
    parameter int DEPTH     = 96,
    parameter int ADDR_BITS = 7,
    parameter int DATA_BITS = 4
) (
    input  logic                 clk_in,
    input  logic                 wr_en_in,
    input  logic [ADDR_BITS-1:0] wr_addr_in,
    input  logic [DATA_BITS-1:0] wr_data_in,
    input  logic [ADDR_BITS-1:0] rd_addr_in,
    output logic [DATA_BITS-1:0] rd_data_out
);

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [DATA_BITS-1:0] rd_s1_q;
    logic [DATA_BITS-1:0] rd_s2_q;

    always_ff @(posedge clk_in) begin
        if (wr_en_in) begin
            mem[wr_addr_in] <= wr_data_in;
        end
        rd_s1_q <= mem[rd_addr_in];
        rd_s2_q <= rd_s1_q;
    end

    assign rd_data_out = rd_s2_q;

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Triple-buffered frame buffer: the renderer fills one bank while the display
// scans another; completed frames are handed over at vertical blank.
module frame_buffer_ctrl #(
    parameter int DISPLAY_WIDTH  = frame_buffer_ctrl_pkg::DISPLAY_WIDTH,
    parameter int DISPLAY_HEIGHT = frame_buffer_ctrl_pkg::DISPLAY_HEIGHT,
    parameter int H_BITS         = frame_buffer_ctrl_pkg::H_BITS,
    parameter int V_BITS         = frame_buffer_ctrl_pkg::V_BITS,
    parameter int COLOR_BITS     = frame_buffer_ctrl_pkg::COLOR_BITS
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [H_BITS-1:0]     hcount_in,
    input  logic [V_BITS-1:0]     vcount_in,
    input  logic [COLOR_BITS-1:0] color_in,
    input  logic                  valid_in,
    input  logic                  new_frame_in,
    input  logic [H_BITS-1:0]     disp_hcount_in,
    input  logic [V_BITS-1:0]     disp_vcount_in,
    input  logic                  vblank_start_in,
    output logic [COLOR_BITS-1:0] disp_color_out,
    output logic [7:0]            frame_count_out,
    output logic                  swap_pending_out
);

    import frame_buffer_ctrl_pkg::*;

    localparam int FRAME_PIXELS = DISPLAY_WIDTH * DISPLAY_HEIGHT;
    localparam int MEM_DEPTH    = NUM_BANKS * FRAME_PIXELS;
    localparam int ADDR_BITS    = $clog2(MEM_DEPTH);

    typedef logic [ADDR_BITS-1:0] addr_t;

    function automatic logic in_frame(input logic [H_BITS-1:0] h, input logic [V_BITS-1:0] v);
        return (32'(h) < 32'(DISPLAY_WIDTH)) && (32'(v) < 32'(DISPLAY_HEIGHT));
    endfunction

    // Every operand is widened to the full address width before multiplying.
    function automatic addr_t pixel_addr(input bank_t bank, input logic [H_BITS-1:0] h,
                                         input logic [V_BITS-1:0] v);
        return addr_t'(bank) * addr_t'(FRAME_PIXELS)
             + addr_t'(v) * addr_t'(DISPLAY_WIDTH)
             + addr_t'(h);
    endfunction

    logic        new_frame_q;
    logic        started_q, started_d;
    bank_t       write_bank_q, write_bank_d;
    bank_t       display_bank_q, display_bank_d;
    bank_t       ready_bank_q, ready_bank_d;
    logic        ready_valid_q, ready_valid_d;
    logic [7:0]  frame_count_q, frame_count_d;
    logic        frame_edge;
    bank_event_e bank_event;

    always_comb begin
        frame_edge = new_frame_in && !new_frame_q;
        bank_event = EV_NONE;
        if (frame_edge && !started_q) begin
            bank_event = EV_START;
        end else if (frame_edge && vblank_start_in) begin
            bank_event = EV_COMPLETE_SWAP;
        end else if (frame_edge) begin
            bank_event = EV_COMPLETE;
        end else if (vblank_start_in && ready_valid_q) begin
            bank_event = EV_PRESENT;
        end
    end

    always_comb begin
        started_d      = started_q;
        write_bank_d   = write_bank_q;
        display_bank_d = display_bank_q;
        ready_bank_d   = ready_bank_q;
        ready_valid_d  = ready_valid_q;
        frame_count_d  = frame_count_q;
        case (bank_event)
            EV_START: begin
                started_d = 1'b1;
            end
            EV_COMPLETE: begin
                ready_bank_d  = write_bank_q;
                ready_valid_d = 1'b1;
                write_bank_d  = third_bank(write_bank_q, display_bank_q);
                frame_count_d = frame_count_q + 8'd1;
            end
            EV_PRESENT: begin
                display_bank_d = ready_bank_q;
                ready_valid_d  = 1'b0;
            end
            // Finished frame goes straight to the display; any older ready frame is dropped.
            EV_COMPLETE_SWAP: begin
                display_bank_d = write_bank_q;
                write_bank_d   = display_bank_q;
                ready_valid_d  = 1'b0;
                frame_count_d  = frame_count_q + 8'd1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            new_frame_q    <= 1'b0;
            started_q      <= 1'b0;
            write_bank_q   <= bank_t'(1);
            display_bank_q <= bank_t'(0);
            ready_bank_q   <= bank_t'(0);
            ready_valid_q  <= 1'b0;
            frame_count_q  <= 8'd0;
        end else begin
            new_frame_q    <= new_frame_in;
            started_q      <= started_d;
            write_bank_q   <= write_bank_d;
            display_bank_q <= display_bank_d;
            ready_bank_q   <= ready_bank_d;
            ready_valid_q  <= ready_valid_d;
            frame_count_q  <= frame_count_d;
        end
    end

    addr_t                  wr1_addr_q, wr1_addr_d, wr2_addr_q, wr2_addr_d;
    logic [COLOR_BITS-1:0]  wr1_color_q, wr1_color_d, wr2_color_q, wr2_color_d;
    logic                   wr1_valid_q, wr1_valid_d, wr2_valid_q, wr2_valid_d;
    addr_t                  rd_addr_q, rd_addr_d;
    logic                   rd_ok_q, rd_ok_d;
    logic [BRAM_READ_LATENCY-1:0] rd_ok_pipe_q, rd_ok_pipe_d;
    logic [COLOR_BITS-1:0]  bram_rd_data;

    // The write bank is sampled here, so a pixel arriving with a frame edge lands in the old bank.
    always_comb begin
        wr1_valid_d  = valid_in && started_q && in_frame(hcount_in, vcount_in);
        wr1_addr_d   = pixel_addr(write_bank_q, hcount_in, vcount_in);
        wr1_color_d  = color_in;
        wr2_valid_d  = wr1_valid_q;
        wr2_addr_d   = wr1_addr_q;
        wr2_color_d  = wr1_color_q;
        rd_ok_d      = in_frame(disp_hcount_in, disp_vcount_in);
        rd_addr_d    = pixel_addr(display_bank_q, disp_hcount_in, disp_vcount_in);
        rd_ok_pipe_d = {rd_ok_pipe_q[BRAM_READ_LATENCY-2:0], rd_ok_q};
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr1_valid_q  <= 1'b0;
            wr2_valid_q  <= 1'b0;
            rd_ok_q      <= 1'b0;
            rd_ok_pipe_q <= '0;
        end else begin
            wr1_valid_q  <= wr1_valid_d;
            wr2_valid_q  <= wr2_valid_d;
            rd_ok_q      <= rd_ok_d;
            rd_ok_pipe_q <= rd_ok_pipe_d;
        end
    end

    always_ff @(posedge clk_in) begin
        wr1_addr_q  <= wr1_addr_d;
        wr1_color_q <= wr1_color_d;
        wr2_addr_q  <= wr2_addr_d;
        wr2_color_q <= wr2_color_d;
        rd_addr_q   <= rd_addr_d;
    end

    frame_bram #(
        .DEPTH     (MEM_DEPTH),
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (COLOR_BITS)
    ) u_bram (
        .clk_in      (clk_in),
        .wr_en_in    (wr2_valid_q),
        .wr_addr_in  (wr2_addr_q),
        .wr_data_in  (wr2_color_q),
        .rd_addr_in  (rd_addr_q),
        .rd_data_out (bram_rd_data)
    );

    // Out-of-range reads, and the cycles just after reset, present black.
    assign disp_color_out   = rd_ok_pipe_q[BRAM_READ_LATENCY-1] ? bram_rd_data : '0;
    assign frame_count_out  = frame_count_q;
    assign swap_pending_out = ready_valid_q;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Scoreboard bench for frame_buffer_ctrl: stimulus pushes expected status and
// read results into queues; a negedge monitor pops and compares them.
module tb_frame_buffer_ctrl;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic [3:0] hcount_in;
    logic [2:0] vcount_in;
    logic [3:0] color_in;
    logic       valid_in;
    logic       new_frame_in;
    logic [3:0] disp_hcount_in;
    logic [2:0] disp_vcount_in;
    logic       vblank_start_in;
    logic [3:0] disp_color_out;
    logic [7:0] frame_count_out;
    logic       swap_pending_out;

    always #5 clk_in = ~clk_in;

    frame_buffer_ctrl #(
        .DISPLAY_WIDTH  (8),
        .DISPLAY_HEIGHT (4),
        .H_BITS         (4),
        .V_BITS         (3),
        .COLOR_BITS     (4)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .hcount_in        (hcount_in),
        .vcount_in        (vcount_in),
        .color_in         (color_in),
        .valid_in         (valid_in),
        .new_frame_in     (new_frame_in),
        .disp_hcount_in   (disp_hcount_in),
        .disp_vcount_in   (disp_vcount_in),
        .vblank_start_in  (vblank_start_in),
        .disp_color_out   (disp_color_out),
        .frame_count_out  (frame_count_out),
        .swap_pending_out (swap_pending_out)
    );

    typedef struct packed {
        logic [7:0] fc;
        logic       sw;
        logic       chk_banks;
        logic [1:0] wb;
        logic [1:0] db;
        logic       rv;
        logic       chk_color;
        logic [3:0] color;
        logic       chk_we;
        logic       we;
    } stat_t;

    typedef struct packed {
        logic [3:0] h;
        logic [2:0] v;
        logic [3:0] color;
    } rd_t;

    stat_t stat_q[$];
    string stat_name_q[$];
    rd_t   rd_q[$];
    logic  stat_req = 1'b0;
    logic  rd_req = 1'b0;
    logic [2:0] rd_tag = 3'b000;
    int    checks = 0;
    int    errors = 0;

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Read-request tag travels alongside the DUT's three-cycle read pipeline.
    always @(posedge clk_in) rd_tag <= {rd_tag[1:0], rd_req};

    always @(negedge clk_in) begin
        if (stat_req) begin
            if (stat_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL status_underflow: got empty queue, expected an entry");
            end else begin
                stat_t s;
                string nm;
                s  = stat_q.pop_front();
                nm = stat_name_q.pop_front();
                $display("[%0t] status %s: frame_count=%0d swap_pending=%0d", $time, nm,
                         frame_count_out, swap_pending_out);
                cmp({nm, ".frame_count"}, int'(frame_count_out), int'(s.fc));
                cmp({nm, ".swap_pending"}, int'(swap_pending_out), int'(s.sw));
                if (s.chk_banks) begin
                    cmp({nm, ".write_bank"}, int'(dut.write_bank_q), int'(s.wb));
                    cmp({nm, ".display_bank"}, int'(dut.display_bank_q), int'(s.db));
                    cmp({nm, ".ready_valid"}, int'(dut.ready_valid_q), int'(s.rv));
                end
                if (s.chk_color) cmp({nm, ".disp_color"}, int'(disp_color_out), int'(s.color));
                if (s.chk_we) cmp({nm, ".bram_we"}, int'(dut.u_bram.wr_en_in), int'(s.we));
            end
        end
        if (rd_tag[2]) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL read_underflow: got empty queue, expected an entry");
            end else begin
                rd_t r;
                r = rd_q.pop_front();
                $display("[%0t] read (%0d,%0d): color=%0h", $time, r.h, r.v, disp_color_out);
                cmp($sformatf("read(%0d,%0d)", r.h, r.v), int'(disp_color_out), int'(r.color));
            end
        end
        if (!rst_in) begin
            checks++;
            if (dut.write_bank_q == dut.display_bank_q ||
                (dut.ready_valid_q && dut.write_bank_q == dut.ready_bank_q)) begin
                errors++;
                $display("FAIL bank_invariant: got write=%0d display=%0d ready=%0d valid=%0d, expected write distinct",
                         dut.write_bank_q, dut.display_bank_q, dut.ready_bank_q, dut.ready_valid_q);
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic write_px(input int h, input int v, input int c);
        hcount_in = 4'(h);
        vcount_in = 3'(v);
        color_in  = 4'(c);
        valid_in  = 1'b1;
        step();
        valid_in  = 1'b0;
    endtask

    task automatic frame_edge();
        new_frame_in = 1'b1;
        step();
        new_frame_in = 1'b0;
    endtask

    task automatic vblank();
        vblank_start_in = 1'b1;
        step();
        vblank_start_in = 1'b0;
    endtask

    task automatic read_px(input int h, input int v, input int exp);
        rd_t r;
        r.h = 4'(h);
        r.v = 3'(v);
        r.color = 4'(exp);
        rd_q.push_back(r);
        disp_hcount_in = 4'(h);
        disp_vcount_in = 3'(v);
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
    endtask

    // A negative argument leaves that field unchecked.
    task automatic expect_status(input string nm, input int fc, input int sw,
                                 input int wb = -1, input int db = -1, input int rv = -1,
                                 input int color = -1, input int we = -1);
        stat_t s;
        s.fc        = 8'(fc);
        s.sw        = 1'(sw);
        s.chk_banks = (wb >= 0);
        s.wb        = 2'(wb);
        s.db        = 2'(db);
        s.rv        = 1'(rv);
        s.chk_color = (color >= 0);
        s.color     = 4'(color);
        s.chk_we    = (we >= 0);
        s.we        = 1'(we);
        stat_q.push_back(s);
        stat_name_q.push_back(nm);
        stat_req = 1'b1;
        step();
        stat_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_in = 1'b0; hcount_in = '0; vcount_in = '0; color_in = '0; valid_in = 1'b0;
        new_frame_in = 1'b0; disp_hcount_in = '0; disp_vcount_in = '0; vblank_start_in = 1'b0;
        #2 rst_in = 1'b1;
        step();
        expect_status("reset", 0, 0, 1, 0, 0, 0);
        rst_in = 1'b0;
        step();
        expect_status("post_reset", 0, 0, 1, 0, 0, 0);

        write_px(2, 0, 15);
        step();
        expect_status("pre_start_drop", 0, 0, -1, -1, -1, -1, 0);

        frame_edge();
        expect_status("first_edge", 0, 0, 1, 0, 0);

        write_px(3, 2, 10);
        step();
        expect_status("write_inrange", 0, 0, -1, -1, -1, -1, 1);
        write_px(0, 2, 3);
        write_px(0, 0, 6);
        write_px(1, 1, 2);
        write_px(8, 1, 5);
        step();
        expect_status("drop_h8", 0, 0, -1, -1, -1, -1, 0);

        hcount_in = 4'd7; vcount_in = 3'd3; color_in = 4'hC; valid_in = 1'b1; new_frame_in = 1'b1;
        step();
        valid_in = 1'b0; new_frame_in = 1'b0;
        expect_status("complete_1", 1, 1, 2, 0, 1);
        vblank();
        expect_status("vblank_1", 1, 0, 2, 1, 0);

        read_px(3, 2, 10);
        read_px(0, 2, 3);
        read_px(0, 0, 6);
        read_px(7, 3, 12);
        read_px(1, 1, 2);
        read_px(8, 0, 0);
        read_px(0, 4, 0);
        idle(3);

        write_px(3, 2, 11);
        write_px(0, 0, 1);
        new_frame_in = 1'b1;
        step();
        step();
        expect_status("hold_mid", 2, 1, 0, 1, 1);
        step();
        step();
        new_frame_in = 1'b0;
        expect_status("hold_end", 2, 1, 0, 1, 1);

        write_px(5, 1, 4);
        write_px(3, 2, 13);
        write_px(0, 4, 9);
        write_px(8, 3, 5);
        step();
        expect_status("drop_oob", 2, 1, -1, -1, -1, -1, 0);
        idle(2);
        read_px(0, 0, 6);
        read_px(3, 2, 10);
        idle(3);

        hcount_in = 4'd5; vcount_in = 3'd1; color_in = 4'hE; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        rst_in = 1'b1;
        step();
        step();
        expect_status("mid_reset", 0, 0, 1, 0, 0, 0);
        rst_in = 1'b0;
        step();

        frame_edge();
        expect_status("restart", 0, 0, 1, 0, 0);
        new_frame_in = 1'b1; vblank_start_in = 1'b1;
        step();
        new_frame_in = 1'b0; vblank_start_in = 1'b0;
        expect_status("edge_vblank", 1, 0, 0, 1, 0);
        read_px(0, 0, 6);
        read_px(3, 2, 10);
        idle(3);

        frame_edge();
        expect_status("complete_2", 2, 1, 2, 1, 1);
        vblank();
        expect_status("vblank_2", 2, 0, 2, 0, 0);
        read_px(5, 1, 4);
        read_px(3, 2, 13);
        idle(3);

        write_px(3, 2, 1);
        frame_edge();
        expect_status("burst_1", 3, 1, 1, 0, 1);
        write_px(3, 2, 7);
        frame_edge();
        expect_status("burst_2", 4, 1, 2, 0, 1);
        write_px(3, 2, 9);
        frame_edge();
        expect_status("burst_3", 5, 1, 1, 0, 1);
        vblank();
        expect_status("vblank_3", 5, 0, 1, 2, 0);
        read_px(3, 2, 9);
        idle(3);
        vblank();
        expect_status("vblank_idle", 5, 0, 1, 2, 0);

        idle(4);
        checks++;
        if (rd_q.size() != 0 || stat_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d reads and %0d status pending, expected 0",
                     rd_q.size(), stat_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
